// File: rtl/seg7_mux_driver_n_if.sv
// seg7_mux_driver_n_if: value/control inputs and display outputs of the multiplexed 7-segment driver
interface seg7_mux_driver_n_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_WIDTH = 14
);
  logic [VALUE_WIDTH-1:0] value;
  logic load;
  logic show_error;
  logic blank_lz;
  logic [NUM_DIGITS-1:0] dp_pos;
  logic [3:0] brightness;
  logic busy;
  logic overflow;
  logic [6:0] seg;
  logic dp;
  logic [NUM_DIGITS-1:0] an;
  modport master (
    output value, load, show_error, blank_lz, dp_pos, brightness,
    input busy, overflow, seg, dp, an
  );
  modport slave (
    input value, load, show_error, blank_lz, dp_pos, brightness,
    output busy, overflow, seg, dp, an
  );
endinterface

// File: rtl/seg7_mux_driver_n.sv
// seg7_mux_driver_n: sequential double-dabble BCD conversion feeding a scanned, PWM-dimmed 7-segment display
module seg7_mux_driver_n #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_WIDTH = 14,
  parameter int REFRESH_BITS = 16,
  parameter int ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst_n,
  seg7_mux_driver_n_if.slave bus
);
  localparam int SD = (VALUE_WIDTH * 302 + 999) / 1000 + 1;
  localparam int SDW = SD > NUM_DIGITS ? SD : NUM_DIGITS;
  localparam int SW = 4 * SDW;
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VALUE_WIDTH);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic INV = ACTIVE_LOW != 0;
  localparam logic [CW-1:0] LAST = CW'(VALUE_WIDTH - 1);
  localparam logic [IW-1:0] TOP = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] TOP1 = IW'(NUM_DIGITS - 2);
  localparam logic [IW-1:0] TOP2 = IW'(NUM_DIGITS - 3);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_R = 7'h50;
  localparam logic [6:0] GLYPH_DASH = 7'h40;
  localparam logic [15:0][6:0] GLYPHS = {{6{7'h00}}, 7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                         7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_d;
  logic start, pending, ovf_q;
  logic [VALUE_WIDTH-1:0] shreg, pend_val, start_val;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scratch, adj;
  logic [DW-1:0] disp;
  logic [REFRESH_BITS-1:0] rc;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic lz, dp_d, dp_q;
  logic [6:0] seg_d, seg_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;
  // a load arriving in COMMIT is newer than anything pending, so it takes the restart
  always_comb begin
    start = (state == IDLE && bus.load) || (state == COMMIT && (bus.load || pending));
    start_val = (state == COMMIT && !bus.load) ? pend_val : bus.value;
    state_d = start ? SHIFT : (state == SHIFT) ? (cnt == LAST ? COMMIT : SHIFT) : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    adj = scratch;
    for (int i = 0; i < SDW; i++)
      adj[4*i +: 4] = scratch[4*i +: 4] >= 4'd5 ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      pending <= 1'b0;
      pend_val <= '0;
      ovf_q <= 1'b0;
      disp <= '0;
      cnt <= '0;
      shreg <= '0;
      scratch <= '0;
    end else begin
      if (start) begin
        shreg <= start_val;
        scratch <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        shreg <= shreg << 1;
        scratch <= SW'({adj, shreg[VALUE_WIDTH-1]});
        cnt <= cnt + 1'b1;
      end
      if (state == COMMIT) begin
        disp <= scratch[DW-1:0];
        ovf_q <= |(scratch >> DW);
      end
      pending <= state != COMMIT && (pending || (state == SHIFT && bus.load));
      if (state == SHIFT && bus.load) pend_val <= bus.value;
    end
  // blanking stops at the highest decimal point so "0.7" keeps its leading zero
  always_comb begin
    nib = disp[{idx, 2'b00} +: 4];
    lz = bus.blank_lz && idx != '0 && (disp >> {idx, 2'b00}) == '0 && (bus.dp_pos >> idx) == '0;
    seg_d = bus.show_error ? (idx == TOP ? GLYPH_E : (idx == TOP1 || idx == TOP2) ? GLYPH_R : 7'h00)
          : ovf_q ? GLYPH_DASH : lz ? 7'h00 : GLYPHS[nib];
    dp_d = !bus.show_error && bus.dp_pos[idx];
    an_d = rc[REFRESH_BITS-1 -: 4] <= bus.brightness ? AN_ONE << idx : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      rc <= '0;
      idx <= '0;
      seg_q <= {7{INV}};
      dp_q <= INV;
      an_q <= {NUM_DIGITS{INV}};
    end else begin
      rc <= rc + 1'b1;
      if (&rc) idx <= idx == TOP ? '0 : idx + 1'b1;
      seg_q <= seg_d ^ {7{INV}};
      dp_q <= dp_d ^ INV;
      an_q <= an_d ^ {NUM_DIGITS{INV}};
    end
  assign bus.busy = state != IDLE;
  assign bus.overflow = ovf_q;
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.an = an_q;
endmodule

// File: tb/tb_seg7_mux_driver_n.sv
// tb_seg7_mux_driver_n: two display configurations driven by shared random stimulus, checked against a decimal-arithmetic model
module tb_seg7_mux_driver_n;
  localparam int RB = 4;
  localparam logic [6:0] GL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic clk = 1'b0;
  logic rst_n;
  logic [26:0] value;
  logic load, show_error, blank_lz;
  logic [7:0] dp_pos;
  logic [3:0] brightness;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic longint p10(input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r *= 10;
    return r;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int ND = g ? 6 : 4;
    localparam int VW = g ? 20 : 14;
    seg7_mux_driver_n_if #(.NUM_DIGITS(ND), .VALUE_WIDTH(VW)) bif ();
    assign bif.value = value[VW-1:0];
    assign bif.load = load;
    assign bif.show_error = show_error;
    assign bif.blank_lz = blank_lz;
    assign bif.dp_pos = dp_pos[ND-1:0];
    assign bif.brightness = brightness;
    seg7_mux_driver_n #(.NUM_DIGITS(ND), .VALUE_WIDTH(VW), .REFRESH_BITS(RB), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bif)
    );
    initial begin
      longint disp_v, cur, pend_v, v, n, s, done_at;
      bit ovf, pend, in_rst, ld, se, bl, on, dpo;
      int d, dig, rc;
      logic [7:0] dpp;
      logic [3:0] br;
      logic [6:0] sg, eseg;
      logic edp, ebusy;
      logic [ND-1:0] ean;
      disp_v = 0; cur = 0; pend_v = 0; n = 0; s = 0; done_at = -1; ovf = 0; pend = 0;
      forever begin
        @(posedge clk);
        in_rst = !rst_n; ld = load; se = show_error; bl = blank_lz; br = brightness;
        v = longint'(value) % (longint'(1) << VW);
        dpp = dp_pos & 8'((1 << ND) - 1);
        n++;
        if (in_rst) begin
          eseg = 7'h7F; edp = 1'b1; ean = '1;
          disp_v = 0; ovf = 0; pend = 0; done_at = -1; s = 0;
        end else begin
          d = int'((s >> RB) % ND);
          rc = int'(s % (1 << RB));
          on = (rc >> (RB - 4)) <= int'(br);
          if (se) begin
            sg = d == ND - 1 ? 7'h79 : (d == ND - 2 || d == ND - 3) ? 7'h50 : 7'h00;
            dpo = 0;
          end else if (ovf) begin
            sg = 7'h40;
            dpo = dpp[d];
          end else begin
            dig = int'((disp_v / p10(d)) % 10);
            sg = (bl && d > 0 && disp_v < p10(d) && int'(dpp) < (1 << d)) ? 7'h00 : GL[dig];
            dpo = dpp[d];
          end
          eseg = ~sg;
          edp = ~dpo;
          for (int i = 0; i < ND; i++) ean[i] = !(on && i == d);
          s++;
          if (done_at == n) begin
            disp_v = cur % p10(ND);
            ovf = cur >= p10(ND);
            if (ld) begin cur = v; pend = 0; done_at = n + VW + 1; end
            else if (pend) begin cur = pend_v; pend = 0; done_at = n + VW + 1; end
            else done_at = -1;
          end else if (done_at >= 0) begin
            if (ld) begin pend = 1; pend_v = v; end
          end else if (ld) begin
            cur = v;
            done_at = n + VW + 1;
          end
        end
        ebusy = done_at >= 0;
        @(negedge clk);
        check($sformatf("cfg%0d seg", g), 64'(bif.seg), 64'(eseg));
        check($sformatf("cfg%0d dp", g), 64'(bif.dp), 64'(edp));
        check($sformatf("cfg%0d an", g), 64'(bif.an), 64'(ean));
        check($sformatf("cfg%0d busy", g), 64'(bif.busy), 64'(ebusy));
        check($sformatf("cfg%0d overflow", g), 64'(bif.overflow), 64'(ovf));
      end
    end
  end
  function automatic logic [7:0] an_of(input int inst);
    return inst != 0 ? {2'b11, cfg[1].bif.an} : {4'hF, cfg[0].bif.an};
  endfunction
  function automatic logic [6:0] seg_of(input int inst);
    return inst != 0 ? cfg[1].bif.seg : cfg[0].bif.seg;
  endfunction
  task automatic wait_an(input int inst, input logic [7:0] want, input string tag);
    bit found;
    found = an_of(inst) === want;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = an_of(inst) === want;
    end
    check({tag, " reached"}, 64'(found), 64'd1);
  endtask
  task automatic load_wait(input logic [26:0] v);
    value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 200 && (cfg[0].bif.busy || cfg[1].bif.busy); i++) @(negedge clk);
    check("conversion done", 64'(cfg[0].bif.busy | cfg[1].bif.busy), 64'd0);
    @(negedge clk);
  endtask
  initial begin
    int cnt, h, sel;
    logic [7:0] want;
    rst_n = 1'b0; value = '0; load = 1'b0; show_error = 1'b0; blank_lz = 1'b0;
    dp_pos = '0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    check("reset an", 64'(cfg[0].bif.an), 64'hF);
    check("reset seg", 64'(cfg[0].bif.seg), 64'h7F);
    check("reset busy", 64'(cfg[0].bif.busy), 64'd0);
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) begin
      want = 8'hFF ^ (8'h1 << d);
      wait_an(0, want, "scan digit");
      check("scan zero glyph", 64'(seg_of(0)), 64'b1000000);
      h = 1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (an_of(0) !== want) break;
        h++;
      end
      check("scan hold", 64'(h), 64'd16);
    end
    value = 27'd1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100 && cfg[0].bif.busy; i++) begin cnt++; @(negedge clk); end
    check("busy length", 64'(cnt), 64'd15);
    for (int i = 0; i < 30; i++) @(negedge clk);
    wait_an(0, 8'hF7, "digit3 of 1234");
    check("1234 digit3", 64'(seg_of(0)), 64'b1111001);
    wait_an(0, 8'hFE, "digit0 of 1234");
    check("1234 digit0", 64'(seg_of(0)), 64'b0011001);
    blank_lz = 1'b1;
    load_wait(27'd7);
    wait_an(0, 8'hF7, "blank digit3");
    check("lz digit3", 64'(seg_of(0)), 64'h7F);
    wait_an(0, 8'hFE, "seven digit0");
    check("lz digit0", 64'(seg_of(0)), 64'b1111000);
    dp_pos = 8'b0100;
    @(negedge clk);
    wait_an(0, 8'hFB, "dp digit2");
    check("dp digit2 seg", 64'(seg_of(0)), 64'b1000000);
    check("dp digit2 dp", 64'(cfg[0].bif.dp), 64'd0);
    wait_an(0, 8'hF7, "dp digit3");
    check("dp digit3 seg", 64'(seg_of(0)), 64'h7F);
    blank_lz = 1'b0;
    dp_pos = '0;
    load_wait(27'd12000);
    check("overflow set", 64'(cfg[0].bif.overflow), 64'd1);
    wait_an(0, 8'hFD, "dash digit1");
    check("dash glyph", 64'(seg_of(0)), 64'b0111111);
    load_wait(27'd9999);
    check("overflow clear", 64'(cfg[0].bif.overflow), 64'd0);
    wait_an(0, 8'hF7, "nine digit3");
    check("nine glyph", 64'(seg_of(0)), 64'b0010000);
    value = 27'd100;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100 && cfg[0].bif.busy; k++) begin
      cnt++;
      load = (k == 2 || k == 5);
      value = k == 2 ? 27'd200 : 27'd300;
      @(negedge clk);
    end
    load = 1'b0;
    check("pending busy length", 64'(cnt), 64'd30);
    for (int i = 0; i < 20; i++) @(negedge clk);
    wait_an(0, 8'hFB, "300 digit2");
    check("300 digit2", 64'(seg_of(0)), 64'b0110000);
    wait_an(0, 8'hF7, "300 digit3");
    check("300 digit3", 64'(seg_of(0)), 64'b1000000);
    show_error = 1'b1;
    brightness = 4'd3;
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      if (an_of(1) !== 8'hFF) cnt++;
    end
    check("pwm duty", 64'(cnt), 64'd24);
    wait_an(1, 8'hDF, "err digit5");
    check("err E", 64'(seg_of(1)), 64'b0000110);
    wait_an(1, 8'hEF, "err digit4");
    check("err r", 64'(seg_of(1)), 64'b0101111);
    wait_an(1, 8'hFE, "err digit0");
    check("err blank", 64'(seg_of(1)), 64'h7F);
    show_error = 1'b0;
    brightness = 4'd15;
    value = 27'd555;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy cfg0", 64'(cfg[0].bif.busy), 64'd0);
    check("abort busy cfg1", 64'(cfg[1].bif.busy), 64'd0);
    rst_n = 1'b1;
    wait_an(1, 8'hF7, "abort digit3");
    check("abort zero", 64'(seg_of(1)), 64'b1000000);
    for (int i = 0; i < 4000; i++) begin
      load = $urandom_range(0, 15) == 0;
      value = $urandom_range(0, 1) != 0 ? 27'($urandom_range(0, 20000)) : 27'($urandom);
      show_error = show_error ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        sel = int'($urandom_range(0, 8));
        dp_pos = sel == 8 ? 8'h0 : 8'h1 << sel;
      end
      if ($urandom_range(0, 63) == 0) brightness = 4'($urandom_range(0, 15));
      rst_n = $urandom_range(0, 799) != 0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    load = 1'b0;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
